instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage and IF/ID pipeline register of the 32-bit MIPS core. Holds the PC, fetches one 32-bit word per cycle from instruction memory over a request/valid handshake, and splits the latched instruction into its fields. Imm16 feeds the sign-extension unit in decode. Also handles hazard stalls, flushes and branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

- Clk  in  1  clock, rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- IMemReq  out  1  fetch request; combinational from state; 0 while Rst_n=0.
- IMemAddr  out  32  word address; stable while IMemReq=1 until IMemValid=1.
- IMemValid  in  1  IMemData valid for the outstanding request; may arrive the same cycle as IMemReq or later.
- IMemData  in  32  fetched instruction word.
- Stall  in  1  hazard unit; hold IF/ID and PC.
- Flush  in  1  squash IF/ID contents.
- BranchTaken  in  1  redirect pulse.
- BranchTarget  in  32  redirect address; bits [1:0] ignored (forced 0).
- Valid  out  1  IF/ID holds a live instruction.
- Instruction  out  32  IF/ID instruction register.
- PCPlus4  out  32  IF/ID copy of fetch PC+4.
- Opcode [31:26], Rs [25:21], Rt [20:16], Rd [15:11], Shamt [10:6], Funct [5:0], Imm16 [15:0], JumpIndex [25:0]  out  combinational slices of Instruction.

## Operation
- Registers:
  - PC.
  - AddrHold (32).
  - Skid buffer: SkidData, SkidPC4.
  - IF/ID: Valid, Instruction, PCPlus4.
  - State ∈ {FETCH, BUFFERED, DRAIN}.
- Reset (Rst_n=0 at edge):
  - PC=RESET_PC, AddrHold=RESET_PC.
  - Valid=0, Instruction=32'h0 (NOP), PCPlus4=0.
  - Skid cleared, State=FETCH.
- FETCH: IMemReq=1, IMemAddr=PC.
  - IMemValid=1, Stall=0: IF/ID ← {1, IMemData, PC+4}; PC ← PC+4.
  - IMemValid=1, Stall=1: Skid ← {IMemData, PC+4}; PC unchanged; → BUFFERED.
  - IMemValid=0: IF/ID gets Valid←0 only if Stall=0 (bubble), else held.
- BUFFERED: IMemReq=0.
  - Stall=0: IF/ID ← {1, Skid}; PC ← PC+4; → FETCH.
  - Stall=1: hold.
- DRAIN: IMemReq=1, IMemAddr=AddrHold.
  - Returned data is discarded.
  - On IMemValid=1 → FETCH.
  - Valid is held 0.
- BranchTaken=1 overrides Stall and all data movement:
  - PC ← {BranchTarget[31:2],2'b00}; Valid ← 0; Skid discarded.
  - From FETCH with IMemValid=0: AddrHold ← old PC; → DRAIN.
  - From FETCH with IMemValid=1: data discarded; stay in FETCH.
  - From BUFFERED → FETCH.
  - From DRAIN: stay in DRAIN; AddrHold unchanged.
- Flush=1 (no BranchTaken): Valid ← 0 at the edge; Instruction/PCPlus4 may update; PC and State advance as normal. Flush beats Stall for Valid.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Skid depth is 1. No new request is issued while it is occupied.

## Timing
- Latency: a request at PC in cycle n with IMemValid=1 in cycle n gives Instruction/Valid updated at the edge ending cycle n, visible in cycle n+1.
- Throughput: 1 instruction/cycle when IMemValid is tied high and Stall=0.
- First IMemReq=1 is the first cycle with Rst_n=1. IMemAddr=RESET_PC in that cycle.
- Stall release from BUFFERED: the buffered instruction appears the cycle after Stall falls; the next request issues that same following cycle.
- Redirect with IMemValid tied high: the target fetch request is issued the cycle after BranchTaken; its instruction is visible 2 cycles after BranchTaken.
- Redirect with a pending response (DRAIN): the target request issues the cycle after IMemValid.
- Rst_n=0 mid-operation (any state, outstanding request): the reset values above apply at that edge. Any in-flight response arriving after reset is ignored only if the memory also resets (system requirement).

## Test plan
- Reset, RESET_PC=32'h0040_0000, IMemValid tied 1, memory returns word=address:
  - Instruction = 32'h0040_0000, 32'h0040_0004, … on consecutive cycles.
  - PCPlus4 = address+4; Valid=1 from cycle 2.
- Stall high 3 cycles while the response is valid:
  - State goes to BUFFERED; IMemReq=0; IF/ID held.
  - After release, the buffered word appears once, with no skip or duplicate.
- BranchTaken, target 32'h0000_1003, during a 3-cycle-latency memory response:
  - DRAIN; IMemAddr stays on the old PC until IMemValid; that data is discarded.
  - Next request is at 32'h0000_1000; Valid=0 throughout.
- Flush and Stall asserted together:
  - Valid=0 the next cycle; PC unchanged.
  - BranchTaken+Stall: PC = target.
- Instruction 32'h2128_FFF6 (addi $t0,$t1,-10): Opcode=6'h08, Rs=9, Rt=8, Imm16=16'hFFF6.
- PC=32'hFFFF_FFFC fetch: next PC=0, PCPlus4=0.
- Rst_n low in DRAIN: all outputs at reset values the next cycle.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage and IF/ID pipeline register for the 32-bit MIPS core.
// Holds the PC and fetches one word per cycle over a request/valid handshake.
// A one-entry skid buffer absorbs a response that lands while decode is stalled.
// A redirect issued with a response still outstanding drains that response first.
// The latched instruction is split combinationally into its MIPS fields.
//
// Ports:
//   Clk, Rst_n         clock (rising edge), synchronous active-low reset
//   IMemReq/IMemAddr   fetch request and word address (combinational from state)
//   IMemValid/IMemData response handshake and fetched word
//   Stall, Flush       hazard-unit hold and IF/ID squash
//   BranchTaken/Target redirect pulse and target (bits [1:0] forced to 0)
//   Valid, Instruction, PCPlus4   IF/ID register outputs
//   Opcode..JumpIndex  combinational slices of Instruction
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        Valid,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4,
  output logic [5:0]  Opcode,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  output logic [15:0] Imm16,
  output logic [25:0] JumpIndex
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_BUFFERED = 2'd1,
    S_DRAIN    = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_addr_hold;
  logic [XLEN-1:0]   r_skid_data;
  logic [XLEN-1:0]   r_skid_pc4;
  logic              r_valid;
  logic [XLEN-1:0]   r_instr;
  logic [XLEN-1:0]   r_pc4;
  logic [XLEN-1:0]   w_pc_inc;
  logic [XLEN-1:0]   w_target;

  // Wraps modulo 2^32 naturally.
  assign w_pc_inc = r_pc + XLEN'(4);
  // Word-align the redirect target.
  assign w_target = BranchTarget & ~XLEN'(3);

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a redirect takes priority over stall and data movement.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (BranchTaken)             w_state_nxt = IMemValid ? S_FETCH : S_DRAIN;
        else if (IMemValid && Stall) w_state_nxt = S_BUFFERED;
      end
      S_BUFFERED: begin
        if (BranchTaken || !Stall) w_state_nxt = S_FETCH;
      end
      S_DRAIN: begin
        if (!BranchTaken && IMemValid) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Request outputs; DRAIN keeps presenting the old address until it is answered.
  always_comb begin
    IMemReq  = 1'b0;
    IMemAddr = r_pc;
    case (r_state)
      S_FETCH: IMemReq = Rst_n;
      S_DRAIN: begin
        IMemReq  = Rst_n;
        IMemAddr = r_addr_hold;
      end
      default: IMemReq = 1'b0;
    endcase
  end

  // PC, skid buffer and IF/ID datapath.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_pc        <= RESET_PC;
      r_addr_hold <= RESET_PC;
      r_skid_data <= '0;
      r_skid_pc4  <= '0;
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_pc4       <= '0;
    end else if (BranchTaken) begin
      r_pc        <= w_target;
      r_valid     <= 1'b0;
      r_skid_data <= '0;
      r_skid_pc4  <= '0;
      // Remember the unanswered address so DRAIN can keep the request stable.
      if (r_state == S_FETCH && !IMemValid) r_addr_hold <= r_pc;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (IMemValid) begin
            if (!Stall) begin
              r_valid <= 1'b1;
              r_instr <= IMemData;
              r_pc4   <= w_pc_inc;
              r_pc    <= w_pc_inc;
            end else begin
              r_skid_data <= IMemData;
              r_skid_pc4  <= w_pc_inc;
            end
          end else if (!Stall) begin
            r_valid <= 1'b0;
          end
        end
        S_BUFFERED: begin
          if (!Stall) begin
            r_valid <= 1'b1;
            r_instr <= r_skid_data;
            r_pc4   <= r_skid_pc4;
            r_pc    <= w_pc_inc;
          end
        end
        S_DRAIN: r_valid <= 1'b0;
        default: r_valid <= 1'b0;
      endcase
      // Flush squashes the slot regardless of stall; later assignment wins.
      if (Flush) r_valid <= 1'b0;
    end
  end

  assign Valid       = r_valid;
  assign Instruction = r_instr;
  assign PCPlus4     = r_pc4;

  assign Opcode    = r_instr[31:26];
  assign Rs        = r_instr[25:21];
  assign Rt        = r_instr[20:16];
  assign Rd        = r_instr[15:11];
  assign Shamt     = r_instr[10:6];
  assign Funct     = r_instr[5:0];
  assign Imm16     = r_instr[15:0];
  assign JumpIndex = r_instr[25:0];

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemValid;
  logic [31:0] IMemData;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Valid;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic [5:0]  Opcode;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [5:0]  Funct;
  logic [15:0] Imm16;
  logic [25:0] JumpIndex;

  always #5 Clk = ~Clk;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemValid(IMemValid), .IMemData(IMemData),
    .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Valid(Valid), .Instruction(Instruction), .PCPlus4(PCPlus4),
    .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt),
    .Funct(Funct), .Imm16(Imm16), .JumpIndex(JumpIndex)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending fetched word awaiting decode, and an
  // orphaned request whose response must be thrown away.
  typedef struct packed { logic [31:0] data; logic [31:0] pc4; } ent_t;
  logic [31:0] m_pc;
  ent_t        m_skid[$];
  logic [31:0] m_orphan[$];
  logic        m_valid;
  logic [31:0] m_instr, m_pc4;

  // Memory contents: word = address ^ key.
  logic [31:0] mem_key = 32'h0;
  logic        frc_en = 1'b0;
  logic [31:0] frc_data = 32'h0;

  task automatic model_edge(input logic rst, input logic vld, input logic [31:0] d,
                            input logic stall, input logic flush, input logic br,
                            input logic [31:0] tgt);
    ent_t e;
    if (!rst) begin
      m_pc = RST_PC; m_skid.delete(); m_orphan.delete();
      m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
    end else if (br) begin
      if (m_orphan.size() == 0 && m_skid.size() == 0 && !vld) m_orphan.push_back(m_pc);
      m_skid.delete();
      m_pc = {tgt[31:2], 2'b00};
      m_valid = 1'b0;
    end else begin
      if (m_orphan.size() != 0) begin
        m_valid = 1'b0;
        if (vld) m_orphan.delete();
      end else if (m_skid.size() != 0) begin
        if (!stall) begin
          e = m_skid.pop_front();
          m_valid = 1'b1; m_instr = e.data; m_pc4 = e.pc4;
          m_pc = m_pc + 32'd4;
        end
      end else if (vld) begin
        if (!stall) begin
          m_valid = 1'b1; m_instr = d; m_pc4 = m_pc + 32'd4;
          m_pc = m_pc + 32'd4;
        end else begin
          e.data = d; e.pc4 = m_pc + 32'd4;
          m_skid.push_back(e);
        end
      end else if (!stall) begin
        m_valid = 1'b0;
      end
      if (flush) m_valid = 1'b0;
    end
  endtask

  // One clock: drive inputs, check request outputs, clock, check IF/ID.
  task automatic cyc(input logic rst, input logic vld, input logic stall,
                     input logic flush, input logic br, input logic [31:0] tgt);
    logic [31:0] a, d;
    logic        exp_req;
    a = (m_orphan.size() != 0) ? m_orphan[0] : m_pc;
    d = frc_en ? frc_data : (vld ? (a ^ mem_key) : $urandom());
    Rst_n = rst; IMemValid = vld; IMemData = d; Stall = stall;
    Flush = flush; BranchTaken = br; BranchTarget = tgt;
    #1;
    exp_req = rst && (m_skid.size() == 0);
    chk("req", 32'(IMemReq), 32'(exp_req));
    if (exp_req) chk("addr", IMemAddr, a);
    @(posedge Clk);
    model_edge(rst, vld, d, stall, flush, br, tgt);
    #1;
    chk("valid", 32'(Valid), 32'(m_valid));
    chk("instr", Instruction, m_instr);
    chk("pc4", PCPlus4, m_pc4);
    chk("fields", {Opcode, Rs, Rt, Rd, Shamt, Funct}, m_instr);
    chk("imm16", 32'(Imm16), 32'(m_instr[15:0]));
    chk("jidx", 32'(JumpIndex), 32'(m_instr[25:0]));
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] ji;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h2128_FFF6, 6'h08, 5'd9,  5'd8,  5'd31, 5'd31, 6'h36, 16'hFFF6, 26'h128_FFF6};
    vecs[1] = '{32'h012A_4020, 6'h00, 5'd9,  5'd10, 5'd8,  5'd0,  6'h20, 16'h4020, 26'h12A_4020};
    vecs[2] = '{32'h0810_0004, 6'h02, 5'd0,  5'd16, 5'd0,  5'd0,  6'h04, 16'h0004, 26'h010_0004};
    vecs[3] = '{32'hFFFF_FFFF, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF};
    vecs[4] = '{32'h0000_0000, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h000_0000};

    Rst_n = 1'b0; IMemValid = 1'b0; IMemData = 32'h0; Stall = 1'b0;
    Flush = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
    m_pc = RST_PC; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;

    // Reset
    cyc(0, 0, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 0, 32'h0);
    chk("rst_valid", 32'(Valid), 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_pc4", PCPlus4, 32'h0);
    chk("rst_req", 32'(IMemReq), 32'h0);

    // Streaming with memory returning word = address
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0, 0, 32'h0);
      chk("seq_instr", Instruction, RST_PC + 32'(i * 4));
      chk("seq_pc4", PCPlus4, RST_PC + 32'(i * 4 + 4));
      chk("seq_valid", 32'(Valid), 32'h1);
    end

    // Stall three cycles with the response valid
    cyc(1, 1, 1, 0, 0, 32'h0);
    chk("stall_req", 32'(IMemReq), 32'h0);
    chk("stall_hold", Instruction, RST_PC + 32'd12);
    cyc(1, 0, 1, 0, 0, 32'h0);
    cyc(1, 0, 1, 0, 0, 32'h0);
    chk("stall_hold2", Instruction, RST_PC + 32'd12);
    cyc(1, 0, 0, 0, 0, 32'h0);
    chk("release_instr", Instruction, RST_PC + 32'd16);
    chk("release_valid", 32'(Valid), 32'h1);
    chk("release_req", 32'(IMemReq), 32'h1);
    chk("release_addr", IMemAddr, RST_PC + 32'd20);
    cyc(1, 1, 0, 0, 0, 32'h0);
    chk("after_release", Instruction, RST_PC + 32'd20);

    // Redirect with a 3-cycle memory response outstanding
    cyc(1, 0, 0, 0, 1, 32'h0000_1003);
    chk("drain_addr", IMemAddr, RST_PC + 32'd24);
    chk("drain_valid", 32'(Valid), 32'h0);
    cyc(1, 0, 0, 0, 0, 32'h0);
    chk("drain_addr2", IMemAddr, RST_PC + 32'd24);
    cyc(1, 1, 0, 0, 0, 32'h0);
    chk("drain_discard", 32'(Valid), 32'h0);
    chk("target_addr", IMemAddr, 32'h0000_1000);
    cyc(1, 1, 0, 0, 0, 32'h0);
    chk("target_instr", Instruction, 32'h0000_1000);
    chk("target_pc4", PCPlus4, 32'h0000_1004);

    // Flush with stall: slot squashed, PC held
    cyc(1, 0, 1, 1, 0, 32'h0);
    chk("flush_valid", 32'(Valid), 32'h0);
    chk("flush_pc", IMemAddr, 32'h0000_1004);
    // Redirect with stall: PC goes to target
    cyc(1, 1, 1, 0, 1, 32'h0000_2000);
    chk("br_stall_addr", IMemAddr, 32'h0000_2000);
    chk("br_stall_valid", 32'(Valid), 32'h0);

    // PC wrap at the top of the address space
    cyc(1, 1, 0, 0, 1, 32'hFFFF_FFFE);
    chk("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0, 0, 32'h0);
    chk("wrap_pc4", PCPlus4, 32'h0);
    chk("wrap_next", IMemAddr, 32'h0);

    // Field decode vectors
    frc_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frc_data = vecs[i].instr;
      cyc(1, 1, 0, 0, 0, 32'h0);
      chk("vec_op", 32'(Opcode), 32'(vecs[i].op));
      chk("vec_rs", 32'(Rs), 32'(vecs[i].rs));
      chk("vec_rt", 32'(Rt), 32'(vecs[i].rt));
      chk("vec_rd", 32'(Rd), 32'(vecs[i].rd));
      chk("vec_sh", 32'(Shamt), 32'(vecs[i].sh));
      chk("vec_fn", 32'(Funct), 32'(vecs[i].fn));
      chk("vec_imm", 32'(Imm16), 32'(vecs[i].imm));
      chk("vec_ji", 32'(JumpIndex), 32'(vecs[i].ji));
    end
    frc_en = 1'b0;

    // Reset while draining
    cyc(1, 0, 0, 0, 1, 32'h0000_3000);
    cyc(0, 0, 0, 0, 0, 32'h0);
    chk("rst_drain_valid", 32'(Valid), 32'h0);
    chk("rst_drain_instr", Instruction, 32'h0);
    chk("rst_drain_pc4", PCPlus4, 32'h0);
    chk("rst_drain_req", 32'(IMemReq), 32'h0);
    cyc(1, 1, 0, 0, 0, 32'h0);
    chk("rst_drain_first", Instruction, RST_PC);

    // Randomized traffic against the model
    mem_key = 32'h5A5A_C3C3;
    for (int i = 0; i < 3000; i++) begin
      logic r, v, s, f, b;
      r = ($urandom_range(0, 199) != 0);
      v = (m_skid.size() == 0) && ($urandom_range(0, 99) < 60);
      s = ($urandom_range(0, 99) < 30);
      f = ($urandom_range(0, 99) < 10);
      b = ($urandom_range(0, 99) < 8);
      cyc(r, v, s, f, b, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
